// File: rtl/nic_pkg.sv
// Shared types and constants for the receive frame controller and its output FIFO.
package nic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_PAYLOAD,
      ST_DROP
   } rx_state_e;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   localparam int DEFAULT_MAX_FRAME_BYTES = 1518;
   localparam int DEFAULT_MIN_FRAME_BYTES = 64;

   localparam int FIFO_ENTRY_W = 11;

   typedef struct packed {
      logic       err;
      logic       eof;
      logic       sof;
      logic [7:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/rx_ctrl_fifo.sv
// Synchronous output FIFO; pointers carry one extra wrap bit to tell full from empty.
module rx_ctrl_fifo
   import nic_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        push,
   input  fifo_entry_t push_data,
   input  logic        pop,
   output fifo_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   fifo_entry_t mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/rx_frame_controller.sv
// Strips preamble/SFD, checks frame length and queues payload bytes with sof/eof/err flags.
// Optional statistics counters are enabled by defining RX_FRAME_STATS_EN.
module rx_frame_controller
   import nic_pkg::*;
#(
   parameter int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES,
   parameter int MIN_FRAME_BYTES = DEFAULT_MIN_FRAME_BYTES,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        frame_active,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_err
`ifdef RX_FRAME_STATS_EN
   ,
   output logic [15:0] frame_count,
   output logic [15:0] err_count
`endif
);

   localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_FRAME_BYTES);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME_BYTES);

   rx_state_e   state_q, state_d;
   logic [7:0]  held_q, held_d;
   logic        have_q, have_d;
   logic        sof_q, sof_d;
   logic        end_q, end_d;
   logic        pend_q, pend_d;
   logic [CW-1:0] count_q, count_d;

   logic        push_req;
   fifo_entry_t push_entry;
   logic        fifo_space;
   logic        fifo_push;
   fifo_entry_t fifo_data;
   fifo_entry_t fifo_head;
   fifo_entry_t out_entry;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;

   assign fifo_pop   = out_ready && !fifo_empty;
   assign fifo_space = !fifo_full || fifo_pop;

   always_comb begin
      state_d    = state_q;
      held_d     = held_q;
      have_d     = have_q;
      sof_d      = sof_q;
      end_d      = end_q;
      pend_d     = pend_q;
      count_d    = count_q;
      push_req   = 1'b0;
      push_entry = '0;
      fifo_push  = 1'b0;
      fifo_data  = '0;
      case (state_q)
         ST_IDLE: begin
            if (frame_active) state_d = pend_q ? ST_DROP : ST_PREAMBLE;
         end
         ST_PREAMBLE: begin
            if (!frame_active) begin
               state_d = ST_IDLE;
            end else if (byte_valid) begin
               if (byte_in == SFD_BYTE) begin
                  state_d = ST_PAYLOAD;
                  count_d = '0;
                  have_d  = 1'b0;
                  sof_d   = 1'b1;
                  end_d   = 1'b0;
               end else if (byte_in != PREAMBLE_BYTE) begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_PAYLOAD: begin
            // end_q marks a last byte that arrived together with the envelope falling.
            if (end_q || (!frame_active && !byte_valid)) begin
               state_d = ST_IDLE;
               end_d   = 1'b0;
               if (have_q) begin
                  push_req   = 1'b1;
                  push_entry = {(count_q < MIN_C), 1'b1, sof_q, held_q};
               end
            end else if (byte_valid) begin
               if (count_q == MAX_C) begin
                  push_req   = 1'b1;
                  push_entry = {1'b1, 1'b1, sof_q, held_q};
                  state_d    = ST_DROP;
               end else begin
                  if (have_q) begin
                     push_req   = 1'b1;
                     push_entry = {1'b0, 1'b0, sof_q, held_q};
                     sof_d      = 1'b0;
                  end
                  held_d  = byte_in;
                  have_d  = 1'b1;
                  count_d = count_q + 1'b1;
                  end_d   = !frame_active;
               end
            end
         end
         default: begin
            if (!frame_active) state_d = ST_IDLE;
         end
      endcase

      if (push_req) begin
         if (fifo_space) begin
            fifo_push = 1'b1;
            fifo_data = push_entry;
         end else begin
            state_d = ST_DROP;
            pend_d  = 1'b1;
         end
      end

      // While pending the FSM never pushes, so the terminator owns the write port.
      if (pend_q && fifo_space) begin
         fifo_push = 1'b1;
         fifo_data = {1'b1, 1'b1, 1'b0, 8'h00};
         pend_d    = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         held_q  <= 8'h00;
         have_q  <= 1'b0;
         sof_q   <= 1'b0;
         end_q   <= 1'b0;
         pend_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         have_q  <= have_d;
         sof_q   <= sof_d;
         end_q   <= end_d;
         pend_q  <= pend_d;
         count_q <= count_d;
      end
   end

   rx_ctrl_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (fifo_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_entry = fifo_empty ? '0 : fifo_head;
   assign out_valid = !fifo_empty;
   assign out_data  = out_entry.data;
   assign out_sof   = out_entry.sof;
   assign out_eof   = out_entry.eof;
   assign out_err   = out_entry.err;

`ifdef RX_FRAME_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [15:0] err_cnt_q;
   logic        frame_inc;
   logic        err_inc;

   assign frame_inc = fifo_push && fifo_data.eof && !fifo_data.err;
   assign err_inc   = (fifo_push && fifo_data.eof && fifo_data.err) ||
                      ((state_q == ST_PREAMBLE) && frame_active && byte_valid &&
                       (byte_in != SFD_BYTE) && (byte_in != PREAMBLE_BYTE));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= 16'h0000;
         err_cnt_q   <= 16'h0000;
      end else begin
         if (frame_inc && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (err_inc && (err_cnt_q != 16'hFFFF))     err_cnt_q   <= err_cnt_q + 16'd1;
      end
   end

   assign frame_count = frame_cnt_q;
   assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench: a frame-level model predicts the popped entries, one process compares them.
module tb_rx_frame_controller;

   localparam int MAXB  = 100;
   localparam int MINB  = 64;
   localparam int DEPTH = 4;
   localparam logic [7:0] PRE = 8'h55;
   localparam logic [7:0] SFD = 8'hD5;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_active = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       byte_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_sof;
   logic       out_eof;
   logic       out_err;
`ifdef RX_FRAME_STATS_EN
   logic [15:0] frame_count;
   logic [15:0] err_count;
`endif

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];
   logic [10:0] rx_log[$];
   bit pending_m = 1'b0;
   int frame_m = 0;
   int err_m = 0;
   int base;

   always #5 clock = ~clock;

   rx_frame_controller #(
      .MAX_FRAME_BYTES (MAXB),
      .MIN_FRAME_BYTES (MINB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .frame_active (frame_active),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .out_err      (out_err)
`ifdef RX_FRAME_STATS_EN
      ,
      .frame_count  (frame_count),
      .err_count    (err_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Frame-level prediction: which entries a frame must produce, given the rules on length and FIFO state.
   task automatic model_frame(input int len, input bit good_sfd, input bit blocked);
      int n;
      logic [10:0] e;
      if (pending_m) return;
      if (!good_sfd) begin
         err_m++;
         return;
      end
      n = (len > MAXB) ? MAXB : len;
      if (n == 0) return;
      if (blocked && n > DEPTH) begin
         for (int i = 0; i < DEPTH; i++) begin
            e = {1'b0, 1'b0, (i == 0), i[7:0]};
            exp_q.push_back(e);
         end
         exp_q.push_back(11'h600);
         err_m++;
         pending_m = 1'b1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         bit last;
         bit bad;
         last = (i == n - 1);
         bad  = last && ((len > MAXB) || (n < MINB));
         e = {bad, last, (i == 0), i[7:0]};
         exp_q.push_back(e);
      end
      if ((len > MAXB) || (n < MINB)) err_m++;
      else frame_m++;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit fall);
      @(posedge clock); #1;
      byte_in = b;
      byte_valid = 1'b1;
      if (fall) frame_active = 1'b0;
      @(posedge clock); #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_frame(input int n_pre, input logic [7:0] sfd, input int len,
                             input bit fall_last, input bit close);
      @(posedge clock); #1;
      frame_active = 1'b1;
      for (int i = 0; i < n_pre; i++) send_byte(PRE, 1'b0);
      send_byte(sfd, 1'b0);
      for (int i = 0; i < len; i++) send_byte(8'(i), fall_last && (i == len - 1));
      if (close) begin
         @(posedge clock); #1;
         frame_active = 1'b0;
         repeat (6) @(posedge clock);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_stats(input string name);
`ifdef RX_FRAME_STATS_EN
      check({name, "_frames"}, frame_count, frame_m);
      check({name, "_errs"}, err_count, err_m);
`endif
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_valid"}, out_valid, 0);
      check({name, "_data"}, out_data, 0);
      check({name, "_sof"}, out_sof, 0);
      check({name, "_eof"}, out_eof, 0);
      check({name, "_err"}, out_err, 0);
   endtask

   // Compare process: every pop against the model, and held entries stay stable under backpressure.
   logic [10:0] prev_e;
   bit prev_hold = 1'b0;
   always @(negedge clock) begin
      logic [10:0] e;
      e = {out_err, out_eof, out_sof, out_data};
      if (!reset_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_entry", e, prev_e);
         end
         if (out_valid && out_ready) begin
            rx_log.push_back(e);
            $display("pop data=%02h sof=%0b eof=%0b err=%0b", out_data, out_sof, out_eof, out_err);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_spurious actual=%03h required=none", e);
            end else begin
               check("out_entry", e, exp_q.pop_front());
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_e = e;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_idle_outputs("reset");
      check_stats("reset");
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clock);

      // Good 64-byte frame
      base = rx_log.size();
      model_frame(64, 1'b1, 1'b0);
      send_frame(7, SFD, 64, 1'b0, 1'b1);
      drain("good_drain");
      check("good_count", rx_log.size() - base, 64);
      check("good_first", rx_log[base], 11'h100);
      check("good_last", rx_log[rx_log.size() - 1], 11'h23F);
      check_stats("good");

      // Runt, last byte coincident with envelope falling
      base = rx_log.size();
      model_frame(10, 1'b1, 1'b0);
      send_frame(7, SFD, 10, 1'b1, 1'b1);
      drain("runt_drain");
      check("runt_count", rx_log.size() - base, 10);
      check("runt_last", rx_log[rx_log.size() - 1], 11'h609);
      check_stats("runt");

      // Bad preamble
      base = rx_log.size();
      model_frame(20, 1'b0, 1'b0);
      send_frame(1, 8'h12, 20, 1'b0, 1'b1);
      drain("badpre_drain");
      check("badpre_count", rx_log.size() - base, 0);
      check_stats("badpre");
`ifdef RX_FRAME_STATS_EN
      check("badpre_errlit", err_count, 2);
`endif

      // Zero payload bytes after SFD
      base = rx_log.size();
      model_frame(0, 1'b1, 1'b0);
      send_frame(7, SFD, 0, 1'b0, 1'b1);
      drain("zero_drain");
      check("zero_count", rx_log.size() - base, 0);

      // Oversize
      base = rx_log.size();
      model_frame(150, 1'b1, 1'b0);
      send_frame(7, SFD, 150, 1'b0, 1'b1);
      drain("over_drain");
      check("over_count", rx_log.size() - base, 100);
      check("over_last", rx_log[rx_log.size() - 1], 11'h663);
      check_stats("over");

      // Backpressure overflow, then a frame dropped while the terminator is pending
      @(posedge clock); #1;
      out_ready = 1'b0;
      base = rx_log.size();
      model_frame(70, 1'b1, 1'b1);
      send_frame(7, SFD, 70, 1'b0, 1'b1);
      model_frame(64, 1'b1, 1'b0);
      send_frame(7, SFD, 64, 1'b0, 1'b1);
      check("bp_stalled_valid", out_valid, 1);
      check("bp_stalled_count", rx_log.size() - base, 0);
      @(posedge clock); #1;
      out_ready = 1'b1;
      drain("bp_drain");
      pending_m = 1'b0;
      check("bp_count", rx_log.size() - base, 5);
      if (rx_log.size() - base == 5) begin
         check("bp_e0", rx_log[base], 11'h100);
         check("bp_e3", rx_log[base + 3], 11'h003);
         check("bp_term", rx_log[base + 4], 11'h600);
      end
      check_stats("bp");
`ifdef RX_FRAME_STATS_EN
      check("bp_errlit", err_count, 4);
`endif

      // Recovery frame
      base = rx_log.size();
      model_frame(64, 1'b1, 1'b0);
      send_frame(7, SFD, 64, 1'b0, 1'b1);
      drain("recover_drain");
      check("recover_count", rx_log.size() - base, 64);
      check_stats("recover");

      // Reset in the middle of the payload, envelope held high across release
      base = rx_log.size();
      for (int i = 0; i < 29; i++) exp_q.push_back({1'b0, 1'b0, (i == 0), i[7:0]});
      send_frame(7, SFD, 30, 1'b0, 1'b0);
      drain("mid_drain");
      check("mid_count", rx_log.size() - base, 29);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      frame_m = 0;
      err_m = 0;
      pending_m = 1'b0;
      check_stats("midrst");
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      base = rx_log.size();
      model_frame(64, 1'b1, 1'b0);
      send_frame(7, SFD, 64, 1'b0, 1'b1);
      drain("post_drain");
      check("post_count", rx_log.size() - base, 64);
      check("post_first", rx_log[base], 11'h100);
      check("post_last", rx_log[rx_log.size() - 1], 11'h23F);
      check_stats("post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
